fir_mac_sequencer: RTL and testbench

//  Time-multiplexed FIR controller for task_01_filter. It sequences one shared 2-cycle multiplier
//  (mult_2t, instantiated beside this block) over TAPS taps per input sample and accumulates the

---
 rtl/fir_seq_pkg.sv | 18 +
 rtl/fir_coef_bank.sv | 29 ++
 rtl/mult_2t.sv | 36 +++
 rtl/fir_mac_sequencer.sv | 123 ++++++++++++
 tb/tb_fir_mac_sequencer.sv | 305 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/fir_seq_pkg.sv
// Shared types and constants for the time-multiplexed FIR MAC sequencer.
package fir_seq_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_e;

  // Edges between presenting operands to mult_2t and its product appearing.
  localparam int MUL_LAT = 2;

  function automatic int tap_w(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/fir_coef_bank.sv
// Coefficient register file: one synchronous write port, one combinational read port by tap index.
module fir_coef_bank #(
  parameter int TAPS   = 8,
  parameter int DATA_W = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     i_we,
  input  logic [$clog2(TAPS)-1:0]  i_waddr,
  input  logic [DATA_W-1:0]        i_wdata,
  input  logic [$clog2(TAPS)-1:0]  i_raddr,
  output logic [DATA_W-1:0]        o_rdata
);

  logic [DATA_W-1:0] r_coef [TAPS];

  // NOTE: the bank is small and must read back as zero after reset, so every entry is
  // reset explicitly; large RAM-style arrays would normally be left unreset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < TAPS; i++) r_coef[i] <= '0;
    end else if (i_we) begin
      r_coef[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata = r_coef[i_raddr];

endmodule

// File: rtl/mult_2t.sv
// Shared two-stage unsigned multiplier; the result is the product truncated to W bits.
module mult_2t #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         enable,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] mult_result
);

  logic [W-1:0]   r_a;
  logic [W-1:0]   r_b;
  logic [W-1:0]   r_p;
  logic [2*W-1:0] w_full;

  assign w_full = {{W{1'b0}}, r_a} * {{W{1'b0}}, r_b};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_a <= '0;
      r_b <= '0;
      r_p <= '0;
    end else begin
      if (enable) begin
        r_a <= a;
        r_b <= b;
      end
      r_p <= w_full[W-1:0];
    end
  end

  assign mult_result = r_p;

endmodule

// File: rtl/fir_mac_sequencer.sv
// FIR controller: owns the delay line and coefficients, streams TAPS products through an
// external 2-cycle multiplier and accumulates them into one result per accepted sample.
module fir_mac_sequencer
  import fir_seq_pkg::*;
#(
  parameter int TAPS   = 8,
  parameter int DATA_W = 8,
  parameter int ACC_W  = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [DATA_W-1:0]        in_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [ACC_W-1:0]         out_data,
  input  logic                     coef_we,
  input  logic [$clog2(TAPS)-1:0]  coef_addr,
  input  logic [DATA_W-1:0]        coef_data,
  output logic                     coef_drop,
  output logic                     mul_en,
  output logic [DATA_W-1:0]        mul_a,
  output logic [DATA_W-1:0]        mul_b,
  input  logic [DATA_W-1:0]        mul_p
);

  localparam int AW = tap_w(TAPS);

  state_e              r_state;
  state_e              w_next_state;
  logic [AW-1:0]       r_k;
  logic [DATA_W-1:0]   r_dl [TAPS];
  logic [ACC_W-1:0]    r_acc;
  logic [MUL_LAT-1:0]  r_vp;
  logic                r_coef_drop;
  logic                w_accept;
  logic                w_coef_wr;
  logic                w_issue_last;
  logic                w_drain_last;
  logic [DATA_W-1:0]   w_coef_rd;

  assign w_accept     = (r_state == IDLE) && in_valid;
  assign w_coef_wr    = coef_we && (r_state == IDLE);
  assign w_issue_last = (r_k == AW'(TAPS - 1));
  assign w_drain_last = (r_k == AW'(MUL_LAT - 1));

  fir_coef_bank #(
    .TAPS   (TAPS),
    .DATA_W (DATA_W)
  ) u_coef_bank (
    .clk     (clk),
    .reset   (reset),
    .i_we    (w_coef_wr),
    .i_waddr (coef_addr),
    .i_wdata (coef_data),
    .i_raddr (r_k),
    .o_rdata (w_coef_rd)
  );

  // NOTE: every output of this block gets a default before the case, so no path leaves a
  // signal unassigned and no latch is inferred.
  always_comb begin
    w_next_state = r_state;
    in_ready     = 1'b0;
    out_valid    = 1'b0;
    mul_en       = 1'b0;
    unique case (r_state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) w_next_state = ISSUE;
      end
      ISSUE: begin
        mul_en = 1'b1;
        if (w_issue_last) w_next_state = DRAIN;
      end
      DRAIN: begin
        if (w_drain_last) w_next_state = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) w_next_state = IDLE;
      end
      default: w_next_state = IDLE;
    endcase
  end

  // NOTE: state is updated with non-blocking assignments so every register samples the
  // pre-edge values of its neighbours, independent of statement order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= IDLE;
      r_k         <= '0;
      r_acc       <= '0;
      r_vp        <= '0;
      r_coef_drop <= 1'b0;
    end else begin
      r_state     <= w_next_state;
      r_vp        <= {r_vp[MUL_LAT-2:0], mul_en};
      r_coef_drop <= coef_we && (r_state != IDLE);
      // The tap/drain counter restarts on every state change.
      if (r_state != w_next_state) r_k <= '0;
      else                         r_k <= r_k + AW'(1);
      if (w_accept)                r_acc <= '0;
      else if (r_vp[MUL_LAT-1])    r_acc <= r_acc + ACC_W'(mul_p);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < TAPS; i++) r_dl[i] <= '0;
    end else if (w_accept) begin
      r_dl[0] <= in_data;
      for (int i = 1; i < TAPS; i++) r_dl[i] <= r_dl[i-1];
    end
  end

  assign out_data  = r_acc;
  assign coef_drop = r_coef_drop;
  assign mul_a     = mul_en ? r_dl[r_k] : '0;
  assign mul_b     = mul_en ? w_coef_rd : '0;

endmodule

// File: tb/tb_fir_mac_sequencer.sv
// Scoreboard bench: two sequencers (16-bit and 8-bit accumulators) share stimulus and are
// checked against a sum-of-truncated-products reference model.
module tb_fir_mac_sequencer;

  localparam int TAPS = 8;
  localparam int DW   = 8;
  localparam int AW   = $clog2(TAPS);

  logic          clk       = 1'b0;
  logic          reset     = 1'b0;
  logic          in_valid  = 1'b0;
  logic [DW-1:0] in_data   = '0;
  logic          dir_ready = 1'b1;
  logic          rnd_ready = 1'b1;
  logic          rand_mode = 1'b0;
  logic          out_ready;
  logic          coef_we   = 1'b0;
  logic [AW-1:0] coef_addr = '0;
  logic [DW-1:0] coef_data = '0;

  logic          in_ready, out_valid, coef_drop, mul_en;
  logic [15:0]   out_data;
  logic [DW-1:0] mul_a, mul_b, mul_p;
  logic          in_ready8, out_valid8, coef_drop8, mul_en8;
  logic [7:0]    out_data8;
  logic [DW-1:0] mul_a8, mul_b8, mul_p8;

  assign out_ready = rand_mode ? rnd_ready : dir_ready;

  always #5 clk = ~clk;

  fir_mac_sequencer #(.TAPS(TAPS), .DATA_W(DW), .ACC_W(16)) u_dut16 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .coef_we(coef_we), .coef_addr(coef_addr), .coef_data(coef_data), .coef_drop(coef_drop),
    .mul_en(mul_en), .mul_a(mul_a), .mul_b(mul_b), .mul_p(mul_p)
  );
  mult_2t #(.W(DW)) u_mul16 (
    .clk(clk), .reset(reset), .enable(mul_en), .a(mul_a), .b(mul_b), .mult_result(mul_p)
  );

  fir_mac_sequencer #(.TAPS(TAPS), .DATA_W(DW), .ACC_W(8)) u_dut8 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready8), .in_data(in_data),
    .out_valid(out_valid8), .out_ready(out_ready), .out_data(out_data8),
    .coef_we(coef_we), .coef_addr(coef_addr), .coef_data(coef_data), .coef_drop(coef_drop8),
    .mul_en(mul_en8), .mul_a(mul_a8), .mul_b(mul_b8), .mul_p(mul_p8)
  );
  mult_2t #(.W(DW)) u_mul8 (
    .clk(clk), .reset(reset), .enable(mul_en8), .a(mul_a8), .b(mul_b8), .mult_result(mul_p8)
  );

  typedef struct {
    int unsigned sum;
    int          edge_no;
  } exp_t;

  exp_t        exp_q[$];
  exp_t        mon_e;
  int unsigned m_dl[TAPS];
  int unsigned m_coef[TAPS];
  int unsigned got16_q[$];
  int unsigned got8_q[$];
  int          checks   = 0;
  int          failures = 0;
  int          cyc      = 0;
  int          last_acc = 0;
  bit          exp_drop = 1'b0;
  bit          tp_mode  = 1'b0;
  bit          tp_have  = 1'b0;
  bit          prev_valid = 1'b0;
  logic [15:0] prev_data  = '0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d, want %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Filter output = sum over taps of (sample * coef) truncated to 8 bits.
  function automatic int unsigned model_sum();
    int unsigned s = 0;
    for (int k = 0; k < TAPS; k++) s += (m_dl[k] * m_coef[k]) % 256;
    return s;
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    #1;
    rnd_ready = ($urandom_range(0, 3) != 0);
  end

  // Stimulus-side scoreboard: model coefficient writes and sample acceptance.
  always @(negedge clk) begin
    if (!reset) begin
      for (int i = 0; i < TAPS; i++) begin
        m_dl[i]   = 0;
        m_coef[i] = 0;
      end
      exp_q.delete();
      exp_drop = 1'b0;
      tp_have  = 1'b0;
    end else begin
      check("coef_drop", 32'(coef_drop), 32'(exp_drop));
      exp_drop = coef_we && !in_ready;
      if (coef_we && in_ready) m_coef[coef_addr] = 32'(coef_data);
      if (!tp_mode) tp_have = 1'b0;
      if (in_valid && in_ready) begin
        for (int i = TAPS - 1; i > 0; i--) m_dl[i] = m_dl[i-1];
        m_dl[0] = 32'(in_data);
        exp_q.push_back('{sum: model_sum(), edge_no: cyc + 1});
        if (tp_mode) begin
          if (tp_have) check("accept_spacing", cyc + 1 - last_acc, TAPS + 4);
          tp_have  = 1'b1;
          last_acc = cyc + 1;
        end
      end
    end
  end

  // Output monitor: latency, hold-while-stalled and result values.
  always @(negedge clk) begin
    if (!reset) begin
      prev_valid = 1'b0;
    end else begin
      check("valid_match", 32'(out_valid8), 32'(out_valid));
      if (prev_valid) check("valid_held", 32'(out_valid), 1);
      if (out_valid) begin
        check("busy_in_ready", 32'(in_ready), 0);
        if (prev_valid)             check("data_stable", 32'(out_data), 32'(prev_data));
        else if (exp_q.size() == 0) check("spurious_result", 32'(out_valid), 0);
        else                        check("latency", cyc - exp_q[0].edge_no, TAPS + 2);
        if (out_ready && exp_q.size() != 0) begin
          mon_e = exp_q.pop_front();
          check("result_acc16", 32'(out_data), int'(mon_e.sum & 32'hffff));
          check("result_acc8", 32'(out_data8), int'(mon_e.sum & 32'hff));
          got16_q.push_back(32'(out_data));
          got8_q.push_back(32'(out_data8));
          prev_valid = 1'b0;
        end else begin
          prev_valid = !out_ready;
          prev_data  = out_data;
        end
      end else begin
        prev_valid = 1'b0;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write_coef(input int a, input int d);
    coef_we   = 1'b1;
    coef_addr = AW'(a);
    coef_data = DW'(d);
    tick();
    coef_we = 1'b0;
  endtask

  task automatic send(input int d, input bit hold = 1'b0, input bit cw = 1'b0,
                      input int ca = 0, input int cd = 0);
    int n = 0;
    in_valid  = 1'b1;
    in_data   = DW'(d);
    coef_we   = cw;
    coef_addr = AW'(ca);
    coef_data = DW'(cd);
    while (!in_ready && n < 200) begin
      tick();
      coef_we = 1'b0;
      n++;
    end
    if (n >= 200) check("send_timeout", n, 0);
    tick();
    coef_we = 1'b0;
    if (!hold) in_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((!in_ready || exp_q.size() != 0) && n < 400) begin
      tick();
      n++;
    end
    if (n >= 400) check("idle_timeout", n, 0);
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_in_ready"},  32'(in_ready), 1);
    check({tag, "_out_valid"}, 32'(out_valid), 0);
    check({tag, "_out_data"},  32'(out_data), 0);
    check({tag, "_out_data8"}, 32'(out_data8), 0);
    check({tag, "_mul_en"},    32'(mul_en), 0);
    check({tag, "_mul_a"},     32'(mul_a), 0);
    check({tag, "_mul_b"},     32'(mul_b), 0);
    check({tag, "_coef_drop"}, 32'(coef_drop), 0);
  endtask

  task automatic impulse(input string tag);
    for (int k = 0; k < TAPS; k++) write_coef(k, k + 1);
    got16_q.delete();
    got8_q.delete();
    send(1);
    repeat (TAPS) send(0);
    wait_idle();
    check({tag, "_count"}, got16_q.size(), TAPS + 1);
    for (int i = 0; i < got16_q.size() && i <= TAPS; i++)
      check({tag, "_out"}, int'(got16_q[i]), (i < TAPS) ? i + 1 : 0);
  endtask

  task automatic steady_255(input string tag, input int coef, input int want16, input int want8);
    for (int k = 0; k < TAPS; k++) write_coef(k, coef);
    got16_q.delete();
    got8_q.delete();
    repeat (TAPS) send(255);
    wait_idle();
    check({tag, "_count"}, got16_q.size(), TAPS);
    if (got16_q.size() != 0) begin
      check({tag, "_last16"}, int'(got16_q[got16_q.size()-1]), want16);
      check({tag, "_last8"},  int'(got8_q[got8_q.size()-1]), want8);
    end
  endtask

  initial begin
    int n;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_vals("por");
    tick();
    reset = 1'b1;

    impulse("impulse");
    steady_255("trunc", 255, 8, 8);
    steady_255("wrap", 1, 2040, 248);

    tp_mode = 1'b1;
    repeat (6) send(int'($urandom_range(0, 255)), 1'b1);
    in_valid = 1'b0;
    tp_mode  = 1'b0;
    wait_idle();

    send(int'($urandom_range(0, 255)));
    n = 0;
    while (!out_valid && n < 40) begin
      tick();
      n++;
    end
    check("bp_reach_done", 32'(out_valid), 1);
    dir_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = DW'($urandom_range(0, 255));
    tick();
    coef_we   = 1'b1;
    coef_addr = AW'($urandom_range(0, TAPS - 1));
    coef_data = DW'($urandom_range(0, 255));
    tick();
    coef_we = 1'b0;
    repeat (3) tick();
    dir_ready = 1'b1;
    send(int'(in_data));
    wait_idle();

    send(int'($urandom_range(1, 255)));
    repeat (4) tick();
    check("mid_mul_en", 32'(mul_en), 1);
    reset = 1'b0;
    #1;
    check_reset_vals("mid");
    tick();
    tick();
    reset = 1'b1;
    impulse("post_reset");

    rand_mode = 1'b1;
    for (int it = 0; it < 40; it++) begin
      repeat ($urandom_range(0, 3)) tick();
      if ($urandom_range(0, 3) == 0)
        write_coef(int'($urandom_range(0, TAPS - 1)), int'($urandom_range(0, 255)));
      send(int'($urandom_range(0, 255)), 1'b0, bit'($urandom_range(0, 1)),
           int'($urandom_range(0, TAPS - 1)), int'($urandom_range(0, 255)));
      if ($urandom_range(0, 2) == 0) begin
        tick();
        write_coef(int'($urandom_range(0, TAPS - 1)), int'($urandom_range(0, 255)));
      end
    end
    rand_mode = 1'b0;
    wait_idle();
    check("queue_empty", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
    $fatal(1, "watchdog expired");
  end

endmodule
